xorwow_core: RTL and testbench
==============================

XORWOW_CORE -- requirements
Module: xorwow_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter D_INC, default 32'd362437, meaning Weyl counter increment.
REQ-003 SHALL have port ACLK  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port ARESETN  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  level; permits generation.
REQ-006 SHALL have port seed_start  input  1  single-cycle pulse; begins seed load.
REQ-007 SHALL have port seed_valid  input  1  seed word valid.
REQ-008 SHALL have port seed_data  input  32  seed word.
REQ-009 SHALL have port seed_ready  output  1  core accepts a seed word.
REQ-010 SHALL have port rnd_valid  output  1  FIFO head valid.
REQ-011 SHALL have port rnd_ready  input  1  consumer accepts head.
REQ-012 SHALL have port rnd_data  output  32  random word.
REQ-013 SHALL have port gen_count  output  32  words generated since reset/seed, wraps at 2^32.
REQ-014 SHALL have port busy  output  1  high in LOAD or RUN.

Function
REQ-015 SHALL hold state words x,y,z,w,v and Weyl counter d, each 32 bits.
REQ-016 One step SHALL compute t=x^(x>>2); x<=y; y<=z; z<=w; w<=v; v<=(v^(v<<4))^(t^(t<<1)); d<=d+D_INC; push (d+D_INC)+v_new into FIFO; all arithmetic mod 2^32.
REQ-017 FSM states IDLE, LOAD, RUN; reset state IDLE.
REQ-018 IDLE: enable=1 -> RUN; seed_start=1 -> LOAD (seed_start has priority over enable).
REQ-019 RUN: one step per cycle when FIFO not full (or becoming non-full by same-cycle pop); enable=0 -> IDLE, no step that cycle; seed_start -> LOAD, no step.
REQ-020 Entering LOAD SHALL flush FIFO (rnd_valid=0 next cycle) and clear gen_count.
REQ-021 LOAD: seed_ready=1; each seed_valid&seed_ready beat loads x,y,z,w,v,d in that order; seed_ready=0 in all other states.
REQ-022 After the 6th beat: if x..v all zero, v SHALL be forced to 32'h1; then -> RUN if enable=1 else IDLE.
REQ-023 seed_start during LOAD SHALL restart the load at word x.
REQ-024 FIFO: first-word-fall-through, rnd_data valid when rnd_valid=1; pop on rnd_valid&rnd_ready; simultaneous push and pop when full SHALL be permitted; data SHALL not change while rnd_valid=1 and rnd_ready=0.
REQ-025 gen_count SHALL increment on every push, wrapping 32'hFFFFFFFF -> 0.
REQ-026 Latency: first rnd_valid SHALL assert one cycle after first RUN step cycle.

Reset
REQ-027 ARESETN low SHALL asynchronously set x=32'd123456789, y=32'd362436069, z=32'd521288629, w=32'd88675123, v=32'd5783321, d=32'd6615241, state IDLE, FIFO empty.
REQ-028 Outputs in reset: seed_ready=0, rnd_valid=0, rnd_data=0, gen_count=0, busy=0.
REQ-029 Reset mid-LOAD or mid-RUN SHALL discard partial seed and FIFO contents; release is synchronous to ACLK.

Structure
REQ-030 Shared package xorwow_pkg SHALL hold FSM state enum, default seed constants, D_INC default, and a step function.
REQ-031 FIFO SHALL be a separate sub-module xorwow_fifo (parameterised depth, width 32).

Verification
REQ-032 Reset, enable=1, rnd_ready=1 -> first rnd_data=32'h0EB70507, gen_count=1 after first push.
REQ-033 Seed all six words 0 -> v forced 1; first rnd_data=32'h000587D6.
REQ-034 rnd_ready=0 with enable=1 -> exactly FIFO_DEPTH pushes, gen_count=4, steps stall, rnd_data stable; release -> sequence continues without gaps or duplicates vs. reference model.
REQ-035 seed_start mid-RUN with FIFO full -> rnd_valid=0 next cycle, gen_count=0, seed_ready=1; second seed_start after 3 beats restarts at x.
REQ-036 enable toggled 1/0 every 3 cycles -> output stream identical to uninterrupted reference-model stream.
REQ-037 ARESETN asserted mid-LOAD -> all outputs at reset values immediately, defaults restored.

Source files
------------

// File: rtl/xorwow_pkg.sv
// Shared types, default seed constants and the xorwow step function.
package xorwow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } xw_fsm_e;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] d;
    } xw_state_t;

    localparam logic [31:0] SEED_X    = 32'd123456789;
    localparam logic [31:0] SEED_Y    = 32'd362436069;
    localparam logic [31:0] SEED_Z    = 32'd521288629;
    localparam logic [31:0] SEED_W    = 32'd88675123;
    localparam logic [31:0] SEED_V    = 32'd5783321;
    localparam logic [31:0] SEED_D    = 32'd6615241;
    localparam logic [31:0] DEF_D_INC = 32'd362437;

    localparam xw_state_t DEFAULT_STATE = '{
        x: SEED_X, y: SEED_Y, z: SEED_Z, w: SEED_W, v: SEED_V, d: SEED_D
    };

    // One xorwow step: shift the word window and advance the Weyl counter.
    function automatic xw_state_t xw_step(input xw_state_t s, input logic [31:0] inc);
        xw_state_t   n;
        logic [31:0] t;
        t   = s.x ^ (s.x >> 2);
        n.x = s.y;
        n.y = s.z;
        n.z = s.w;
        n.w = s.v;
        n.v = (s.v ^ (s.v << 4)) ^ (t ^ (t << 1));
        n.d = s.d + inc;
        return n;
    endfunction

    // Output word derived from a freshly stepped state.
    function automatic logic [31:0] xw_output(input xw_state_t s);
        return s.d + s.v;
    endfunction

endpackage

// File: rtl/xorwow_fifo.sv
// First-word-fall-through output FIFO with synchronous flush.
module xorwow_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && valid_o && !flush_i;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full_o || do_pop);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are only observable through valid entries.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/xorwow_core.sv
// Xorwow random word generator with seed loading and an output FIFO.
module xorwow_core
    import xorwow_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] D_INC      = DEF_D_INC
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic        seed_start,
    input  logic        seed_valid,
    input  logic [31:0] seed_data,
    output logic        seed_ready,
    output logic        rnd_valid,
    input  logic        rnd_ready,
    output logic [31:0] rnd_data,
    output logic [31:0] gen_count,
    output logic        busy
);

    xw_fsm_e     fsm_q, fsm_d;
    xw_state_t   st_q, st_d, st_step;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] gen_count_q;
    logic        step, flush, fifo_full, pop;

    assign seed_ready = (fsm_q == ST_LOAD);
    assign busy       = (fsm_q != ST_IDLE);
    assign gen_count  = gen_count_q;
    assign pop        = rnd_valid && rnd_ready;
    assign st_step    = xw_step(st_q, D_INC);

    // Next-state logic: FSM transitions, seed loading and generator stepping.
    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        idx_d = idx_q;
        step  = 1'b0;
        flush = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (seed_start) begin
                    fsm_d = ST_LOAD;
                    idx_d = '0;
                    flush = 1'b1;
                end else if (enable) begin
                    fsm_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (seed_start) begin
                    fsm_d = ST_LOAD;
                    idx_d = '0;
                    flush = 1'b1;
                end else if (!enable) begin
                    fsm_d = ST_IDLE;
                end else if (!fifo_full || pop) begin
                    step = 1'b1;
                    st_d = st_step;
                end
            end
            ST_LOAD: begin
                if (seed_start) begin
                    idx_d = '0;
                    flush = 1'b1;
                end else if (seed_valid) begin
                    case (idx_q)
                        3'd0:    st_d.x = seed_data;
                        3'd1:    st_d.y = seed_data;
                        3'd2:    st_d.z = seed_data;
                        3'd3:    st_d.w = seed_data;
                        3'd4:    st_d.v = seed_data;
                        default: st_d.d = seed_data;
                    endcase
                    if (idx_q == 3'd5) begin
                        // An all-zero word window would lock the generator at zero.
                        if ((st_q.x | st_q.y | st_q.z | st_q.w | st_q.v) == '0)
                            st_d.v = 32'h1;
                        fsm_d = enable ? ST_RUN : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers: FSM, generator words and seed beat index.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            fsm_q <= ST_IDLE;
            st_q  <= DEFAULT_STATE;
            idx_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            idx_q <= idx_d;
        end
    end

    // Count pushed words; cleared whenever a seed load begins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)   gen_count_q <= '0;
        else if (flush) gen_count_q <= '0;
        else if (step)  gen_count_q <= gen_count_q + 32'd1;
    end

    xorwow_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .flush_i (flush),
        .push_i  (step),
        .data_i  (xw_output(st_step)),
        .pop_i   (pop),
        .data_o  (rnd_data),
        .valid_o (rnd_valid),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_xorwow_core.sv
// Directed self-checking bench for xorwow_core.
module tb_xorwow_core;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        enable, seed_start, seed_valid, rnd_ready;
    logic [31:0] seed_data;
    logic        seed_ready, rnd_valid, busy;
    logic [31:0] rnd_data, gen_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mx, my, mz, mw, mv, md;

    always #5 ACLK = ~ACLK;

    xorwow_core #(
        .FIFO_DEPTH (4),
        .D_INC      (32'd362437)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .enable     (enable),
        .seed_start (seed_start),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .gen_count  (gen_count),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_seed(input logic [31:0] a, b, c, e, f, g);
        mx = a; my = b; mz = c; mw = e; mv = f; md = g;
    endtask

    task automatic model_step(output logic [31:0] r);
        logic [31:0] t;
        t  = mx ^ (mx >> 2);
        mx = my; my = mz; mz = mw; mw = mv;
        mv = (mv ^ (mv << 4)) ^ (t ^ (t << 1));
        md = md + 32'd362437;
        r  = md + mv;
    endtask

    task automatic apply_reset();
        ARESETN = 1'b0; enable = 1'b0; seed_start = 1'b0; seed_valid = 1'b0;
        seed_data = '0; rnd_ready = 1'b0;
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        model_seed(32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123,
                   32'd5783321, 32'd6615241);
    endtask

    // Check every handshaked word against the model until n words or a cycle limit.
    task automatic consume(input string tag, input int n_words, input int max_cycles);
        int got = 0;
        int cyc = 0;
        logic [31:0] exp;
        while (got < n_words && cyc < max_cycles) begin
            if (rnd_valid && rnd_ready) begin
                model_step(exp);
                n_tests++;
                if (rnd_data !== exp) begin
                    n_fail++;
                    $display("FAIL %s word %0d: got %h expected %h", tag, got, rnd_data, exp);
                end
                got++;
            end
            tick();
            cyc++;
        end
        n_tests++;
        if (got < n_words) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d words expected %0d", tag, got, n_words);
        end
    endtask

    task automatic load_seed(input logic [31:0] a, b, c, e, f, g);
        logic [31:0] w [6];
        w[0] = a; w[1] = b; w[2] = c; w[3] = e; w[4] = f; w[5] = g;
        for (int i = 0; i < 6; i++) begin
            seed_valid = 1'b1; seed_data = w[i];
            tick();
        end
        seed_valid = 1'b0; seed_data = '0;
    endtask

    task automatic pulse_seed_start();
        seed_start = 1'b1;
        tick();
        seed_start = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; enable = 1'b0; seed_start = 1'b0; seed_valid = 1'b0;
        seed_data = '0; rnd_ready = 1'b0;
        tick(); tick();
        n_tests++;
        if ({seed_ready, rnd_valid, busy} !== 3'b000 || rnd_data !== '0 || gen_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sr=%b rv=%b busy=%b data=%h cnt=%0d expected all zero",
                     seed_ready, rnd_valid, busy, rnd_data, gen_count);
        end
    endtask

    task automatic test_default_stream();
        apply_reset();
        enable = 1'b1; rnd_ready = 1'b1;
        tick();
        n_tests++;
        if (rnd_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_first_cycle: got rv=%b busy=%b expected rv=0 busy=1", rnd_valid, busy);
        end
        tick();
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== 32'h0EB70507) begin
            n_fail++;
            $display("FAIL first_word: got rv=%b data=%h expected 1 0eb70507", rnd_valid, rnd_data);
        end
        n_tests++;
        if (gen_count !== 32'd1) begin
            n_fail++;
            $display("FAIL first_count: got %0d expected 1", gen_count);
        end
        consume("default_stream", 10, 40);
    endtask

    task automatic test_zero_seed();
        apply_reset();
        pulse_seed_start();
        n_tests++;
        if (seed_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_entry: got sr=%b busy=%b expected 1 1", seed_ready, busy);
        end
        enable = 1'b1;
        load_seed('0, '0, '0, '0, '0, '0);
        n_tests++;
        if (seed_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_exit: got sr=%b expected 0", seed_ready);
        end
        rnd_ready = 1'b1;
        tick();
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== 32'h000587D6) begin
            n_fail++;
            $display("FAIL zero_seed_word: got rv=%b data=%h expected 1 000587d6", rnd_valid, rnd_data);
        end
        model_seed('0, '0, '0, '0, 32'h1, '0);
        consume("zero_seed_stream", 6, 30);
    endtask

    task automatic test_backpressure();
        apply_reset();
        enable = 1'b1; rnd_ready = 1'b0;
        repeat (12) tick();
        n_tests++;
        if (gen_count !== 32'd4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d expected 4", gen_count);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rnd_valid !== 1'b1 || rnd_data !== 32'h0EB70507) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got rv=%b data=%h expected 1 0eb70507", i, rnd_valid, rnd_data);
            end
            tick();
        end
        rnd_ready = 1'b1;
        consume("after_stall", 14, 40);
    endtask

    task automatic test_seed_restart();
        apply_reset();
        enable = 1'b1; rnd_ready = 1'b0;
        repeat (10) tick();
        pulse_seed_start();
        n_tests++;
        if (rnd_valid !== 1'b0 || gen_count !== 32'd0 || seed_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL seed_flush: got rv=%b cnt=%0d sr=%b expected 0 0 1", rnd_valid, gen_count, seed_ready);
        end
        for (int i = 0; i < 3; i++) begin
            seed_valid = 1'b1; seed_data = 32'hDEAD0000 + 32'(i);
            tick();
        end
        seed_valid = 1'b0;
        pulse_seed_start();
        n_tests++;
        if (seed_ready !== 1'b1 || rnd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_state: got sr=%b rv=%b expected 1 0", seed_ready, rnd_valid);
        end
        load_seed(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
        model_seed(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
        rnd_ready = 1'b1;
        consume("restart_stream", 8, 30);
    endtask

    task automatic test_enable_toggle();
        int got = 0;
        logic [31:0] exp;
        apply_reset();
        rnd_ready = 1'b1;
        for (int c = 0; c < 90; c++) begin
            enable = ((c / 3) % 2) == 0;
            if (rnd_valid && rnd_ready) begin
                model_step(exp);
                n_tests++;
                if (rnd_data !== exp) begin
                    n_fail++;
                    $display("FAIL toggle word %0d: got %h expected %h", got, rnd_data, exp);
                end
                got++;
            end
            tick();
        end
        n_tests++;
        if (got < 20) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d words expected at least 20", got);
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        enable = 1'b1; rnd_ready = 1'b0;
        repeat (4) tick();
        pulse_seed_start();
        for (int i = 0; i < 3; i++) begin
            seed_valid = 1'b1; seed_data = 32'hFFFFFFFF;
            tick();
        end
        ARESETN = 1'b0;
        #1;
        n_tests++;
        if ({seed_ready, rnd_valid, busy} !== 3'b000 || rnd_data !== '0 || gen_count !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got sr=%b rv=%b busy=%b data=%h cnt=%0d expected all zero",
                     seed_ready, rnd_valid, busy, rnd_data, gen_count);
        end
        seed_valid = 1'b0;
        tick();
        ARESETN = 1'b1;
        rnd_ready = 1'b1;
        tick(); tick();
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== 32'h0EB70507 || gen_count !== 32'd1) begin
            n_fail++;
            $display("FAIL defaults_restored: got rv=%b data=%h cnt=%0d expected 1 0eb70507 1",
                     rnd_valid, rnd_data, gen_count);
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_zero_seed();
        test_backpressure();
        test_seed_restart();
        test_enable_toggle();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
